score_hud: RTL and testbench
============================

// Module: score_hud
// PURPOSE
//  Parametrised successor of the single-row score renderer. Keeps the run score and a session high
//  score, advances the score on a divided frame tick, adds a one-shot bonus per gift pulse, and blinks
//  the score row on every milestone. For each (WriteX,WriteY) it outputs the sprite-ROM address of the
//  digit pixel. Sits between the game FSM and the sprite ROM/palette mux on the single Clk50 domain.
// PARAMETERS
//  NUM_DIGITS   5       decimal digits per row; score wraps modulo 10**NUM_DIGITS
//  TICK_DIV     10      frame ticks per +1 score step
//  GIFT_BONUS   100     points added per gift rising edge
//  MILESTONE    100     blink when score crosses a multiple of this
//  BLINK_FRAMES 200     blink duration in frame ticks
//  BLINK_PERIOD 50      blink period in frames; row hidden in 2nd half
//  NUM_BASE     168215  ROM address of digit 0; digits contiguous, 0..9
//  DIGIT_W      18      digit sprite width (px)
//  DIGIT_H      21      digit sprite height (px)
//  DIGIT_PITCH  20      x spacing between digit origins (px)
//  SCORE_X      520     x of score row's leftmost digit
//  HI_X         380     x of high-score row's leftmost digit
//  ROW_Y        20      y of both rows
// PORTS
//  Clk50        in   1   system clock
//  Reset_n      in   1   synchronous, active-low reset
//  frame_tick   in   1   one-cycle enable, once per video frame
//  Game_State   in   2   00 start screen, 01 running, 10 game over, 11 treated as 00
//  Dead         in   1   level; player dead
//  gift         in   1   level; rising edge = bonus
//  WriteX       in   10  current pixel x
//  WriteY       in   10  current pixel y
//  digit_on     out  2   registered; 00 off, 01 score row, 10 high-score row
//  address      out  18  registered sprite-ROM address, valid when digit_on!=0
//  score_out    out  32  current score (binary)
//  hi_out       out  32  high score (binary)
// BEHAVIOUR
//  Reset (Reset_n=0 at Clk50 edge): state=IDLE; score, hi, tick_cnt, blink_cnt, gift_q=0;
//   digit_on=00, address=0. Reset mid-run discards score and hi.
//  FSM, evaluated every Clk50:
//   IDLE: score frozen; Game_State==01 -> RUN, clearing score and tick_cnt.
//   RUN: Dead or Game_State==10 -> OVER; on that edge hi<=max(hi,score). Game_State 00/11 -> IDLE.
//   OVER: score frozen; Game_State 00/11 -> IDLE; Game_State==01 && !Dead -> RUN, clears score.
//  Step: only in RUN. On frame_tick, tick_cnt counts 0..TICK_DIV-1. On frame_tick with
//   tick_cnt==TICK_DIV-1, tick_cnt<=0 and step adds 1.
//  Gift: gift_q<=gift each cycle. gift&&!gift_q in RUN adds GIFT_BONUS that cycle. Held level adds once.
//  Step and gift in the same cycle: add 1+GIFT_BONUS in one update.
//  Wrap: new = old+inc; if new >= 10**NUM_DIGITS, subtract 10**NUM_DIGITS.
//  Blink trigger: on any update with new/MILESTONE != old/MILESTONE, excluding the clear to 0.
//   Effect: blink_cnt<=BLINK_FRAMES, restarting if already active.
//  blink_cnt decrements on frame_tick while !=0, in any state.
//  Score row hidden when blink_cnt!=0 && (blink_cnt % BLINK_PERIOD) < BLINK_PERIOD/2.
//   While blink_cnt!=0, the two least-significant displayed digits show 0. High-score row never blinks.
//  Render (registered):
//   Digit i, i=0 most significant, covers x in [X0+i*DIGIT_PITCH, +DIGIT_W), y in [ROW_Y, +DIGIT_H).
//   Leading zeros drawn. Score row takes priority if rows overlap.
//   address = NUM_BASE + d*DIGIT_W*DIGIT_H + dy*DIGIT_W + dx; d is the decimal digit value.
//   dx, dy are the offsets within the digit box.
//   digit_on/address valid one Clk50 after WriteX/WriteY. Outside all boxes: digit_on=00, address=0.
//  Arithmetic: score/hi held in 32-bit binary. Digits extracted combinationally (div/mod 10).
// TESTING
//  T1 reset: hold Reset_n=0 3 cycles with random inputs -> digit_on=00, address=0, score_out=hi_out=0.
//  T2 count: Game_State=01, 25 frame_ticks -> score_out=2. Tick 30 -> 3. Game_State=10 -> frozen, hi_out=3.
//  T3 gift: in RUN, gift held high 5 cycles coincident with a step -> score +101 once, not +500.
//  T4 wrap/milestone: score preset by counting to 99999, one step -> score_out=0.
//   Score 99->100 -> blink_cnt=200. Frames 0-24 visible, 25-49 hidden; row shows ...100.
//   After 200 frames steady.
//  T5 render: score=12345, WriteX=560+3, WriteY=20+2 -> next cycle digit_on=01,
//   address=168215+3*378+2*18+3=169388. WriteX=538 -> digit_on=00.
//  T6 restart: OVER with hi=50, new run reaches 40, dies -> hi_out stays 50. Reset_n=0 mid-run -> all 0.

Source files
------------

// File: rtl/score_hud.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// score_hud
//
// Score / high-score heads-up display for the game. It keeps the running
// score and the session high score. The score advances by one on every
// TICK_DIV-th frame tick. Each rising edge of gift adds GIFT_BONUS points.
// Whenever the score crosses a MILESTONE boundary, the score row blinks.
// For every scan position (WriteX, WriteY) it produces the sprite-ROM
// address of the digit pixel found there, one Clk50 cycle later.
//
// Ports
//   Clk50      : system clock
//   Reset_n    : synchronous, active-low reset
//   frame_tick : one-cycle enable, once per video frame
//   Game_State : 00 start screen, 01 running, 10 game over, 11 as 00
//   Dead       : level, player dead
//   gift       : level, rising edge awards a bonus
//   WriteX/Y   : current pixel coordinates
//   digit_on   : registered, 00 off, 01 score row, 10 high-score row
//   address    : registered sprite-ROM address, valid when digit_on != 0
//   score_out  : current score, binary
//   hi_out     : session high score, binary
// ---------------------------------------------------------------------------
module score_hud #(
    parameter int NUM_DIGITS   = 5,
    parameter int TICK_DIV     = 10,
    parameter int GIFT_BONUS   = 100,
    parameter int MILESTONE    = 100,
    parameter int BLINK_FRAMES = 200,
    parameter int BLINK_PERIOD = 50,
    parameter int NUM_BASE     = 168215,
    parameter int DIGIT_W      = 18,
    parameter int DIGIT_H      = 21,
    parameter int DIGIT_PITCH  = 20,
    parameter int SCORE_X      = 520,
    parameter int HI_X         = 380,
    parameter int ROW_Y        = 20
) (
    input  logic        Clk50,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [1:0]  Game_State,
    input  logic        Dead,
    input  logic        gift,
    input  logic [9:0]  WriteX,
    input  logic [9:0]  WriteY,
    output logic [1:0]  digit_on,
    output logic [17:0] address,
    output logic [31:0] score_out,
    output logic [31:0] hi_out
);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [31:0]   SCORE_MOD  = pow10(NUM_DIGITS);
    localparam logic [31:0]   GIFT_C     = 32'(GIFT_BONUS);
    localparam logic [31:0]   MILE_C     = 32'(MILESTONE);
    localparam logic [31:0]   PERIOD_C   = 32'(BLINK_PERIOD);
    localparam logic [31:0]   HALF_C     = 32'(BLINK_PERIOD / 2);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES);

    logic [1:0]    state_q,    state_d;
    logic [31:0]   score_q,    score_d;
    logic [31:0]   hi_q,       hi_d;
    logic [TW-1:0] tickCnt_q,  tickCnt_d;
    logic [BW-1:0] blinkCnt_q, blinkCnt_d;
    logic          giftPrev_q;
    logic [1:0]    digitOn_q,  digitOn_d;
    logic [17:0]   address_q,  address_d;

    logic          inRun;
    logic          giftRise;
    logic          stepHit;
    logic          milestoneHit;
    logic [31:0]   incAmt;
    logic [31:0]   sumRaw;
    logic [31:0]   wrapped;

    logic [3:0]    scoreDig [NUM_DIGITS];
    logic [3:0]    hiDig    [NUM_DIGITS];
    logic [31:0]   scoreTmp;
    logic [31:0]   hiTmp;
    logic          scoreHidden;
    logic          rowY;
    logic [31:0]   x32;
    logic [31:0]   y32;
    logic [31:0]   dy;
    logic [31:0]   xl;

    // Score increment for this cycle. Step and gift can coincide and are
    // merged into a single add so the wrap and milestone test see the total.
    // The milestone compare is made against the old score, so a wrap past the
    // top also counts as a crossing, while the clear on entering RUN never
    // goes through this path.
    always_comb begin
        inRun    = (state_q == ST_RUN);
        giftRise = gift && !giftPrev_q;
        stepHit  = inRun && frame_tick && (tickCnt_q == TICK_LAST);
        incAmt   = 32'd0;
        if (stepHit) begin
            incAmt = incAmt + 32'd1;
        end
        if (inRun && giftRise) begin
            incAmt = incAmt + GIFT_C;
        end
        sumRaw       = score_q + incAmt;
        wrapped      = (sumRaw >= SCORE_MOD) ? (sumRaw - SCORE_MOD) : sumRaw;
        milestoneHit = (incAmt != 32'd0) && ((wrapped / MILE_C) != (score_q / MILE_C));
    end

    // Game FSM plus score, tick divider and high-score bookkeeping. The high
    // score is folded in on the RUN->OVER edge using the score as updated in
    // that same cycle, so a last-moment point is not lost.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        hi_d      = hi_q;
        tickCnt_d = tickCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Game_State == 2'b01) begin
                    state_d   = ST_RUN;
                    score_d   = 32'd0;
                    tickCnt_d = '0;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    tickCnt_d = (tickCnt_q == TICK_LAST) ? '0 : tickCnt_q + TW'(1);
                end
                if (incAmt != 32'd0) begin
                    score_d = wrapped;
                end
                if (Dead || (Game_State == 2'b10)) begin
                    state_d = ST_OVER;
                    hi_d    = (score_d > hi_q) ? score_d : hi_q;
                end else if ((Game_State == 2'b00) || (Game_State == 2'b11)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: begin
                if ((Game_State == 2'b00) || (Game_State == 2'b11)) begin
                    state_d = ST_IDLE;
                end else if ((Game_State == 2'b01) && !Dead) begin
                    state_d   = ST_RUN;
                    score_d   = 32'd0;
                    tickCnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Blink counter. A new milestone restarts the full blink even while one
    // is already running; otherwise it runs down on frame ticks in any state.
    always_comb begin
        blinkCnt_d = blinkCnt_q;
        if (inRun && milestoneHit) begin
            blinkCnt_d = BLINK_LOAD;
        end else if (frame_tick && (blinkCnt_q != '0)) begin
            blinkCnt_d = blinkCnt_q - BW'(1);
        end
    end

    // Decimal digits, index 0 is the most significant. While blinking, the
    // two least significant score digits are forced to 0.
    always_comb begin
        scoreTmp = score_q;
        hiTmp    = hi_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            scoreDig[NUM_DIGITS-1-k] = 4'(scoreTmp % 32'd10);
            hiDig[NUM_DIGITS-1-k]    = 4'(hiTmp % 32'd10);
            scoreTmp = scoreTmp / 32'd10;
            hiTmp    = hiTmp / 32'd10;
        end
        if (blinkCnt_q != '0) begin
            for (int k = 0; k < 2; k++) begin
                if (k < NUM_DIGITS) begin
                    scoreDig[NUM_DIGITS-1-k] = 4'd0;
                end
            end
        end
        scoreHidden = (blinkCnt_q != '0) && ((32'(blinkCnt_q) % PERIOD_C) < HALF_C);
    end

    // Pixel hit test. The high-score row is tested first and the score row
    // afterwards, so the score row wins wherever the two overlap. A hidden
    // score row lets the high-score row show through.
    always_comb begin
        digitOn_d = 2'b00;
        address_d = '0;
        x32       = 32'(WriteX);
        y32       = 32'(WriteY);
        rowY      = (y32 >= 32'(ROW_Y)) && (y32 < 32'(ROW_Y + DIGIT_H));
        dy        = y32 - 32'(ROW_Y);
        xl        = 32'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            xl = 32'(HI_X + i * DIGIT_PITCH);
            if (rowY && (x32 >= xl) && (x32 < xl + 32'(DIGIT_W))) begin
                digitOn_d = 2'b10;
                address_d = 18'(32'(NUM_BASE) + 32'(hiDig[i]) * 32'(DIGIT_W * DIGIT_H)
                                + dy * 32'(DIGIT_W) + (x32 - xl));
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            xl = 32'(SCORE_X + i * DIGIT_PITCH);
            if (!scoreHidden && rowY && (x32 >= xl) && (x32 < xl + 32'(DIGIT_W))) begin
                digitOn_d = 2'b01;
                address_d = 18'(32'(NUM_BASE) + 32'(scoreDig[i]) * 32'(DIGIT_W * DIGIT_H)
                                + dy * 32'(DIGIT_W) + (x32 - xl));
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk50) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            score_q    <= 32'd0;
            hi_q       <= 32'd0;
            tickCnt_q  <= '0;
            blinkCnt_q <= '0;
            giftPrev_q <= 1'b0;
            digitOn_q  <= 2'b00;
            address_q  <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            hi_q       <= hi_d;
            tickCnt_q  <= tickCnt_d;
            blinkCnt_q <= blinkCnt_d;
            giftPrev_q <= gift;
            digitOn_q  <= digitOn_d;
            address_q  <= address_d;
        end
    end

    assign digit_on  = digitOn_q;
    assign address   = address_q;
    assign score_out = score_q;
    assign hi_out    = hi_q;

endmodule

// File: tb/tb_score_hud.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_score_hud
//
// Directed bench for score_hud with default parameters. Inputs change on the
// falling clock edge and outputs are read on the following falling edge, so
// each stimulus cycle covers exactly one rising edge of Clk50.
// ---------------------------------------------------------------------------
module tb_score_hud;

    logic        clock = 1'b0;
    logic        resetN;
    logic        frameTick;
    logic [1:0]  gameState;
    logic        dead;
    logic        giftIn;
    logic [9:0]  writeX;
    logic [9:0]  writeY;
    logic [1:0]  digitOn;
    logic [17:0] romAddress;
    logic [31:0] scoreOut;
    logic [31:0] hiOut;

    int checkCount = 0;
    int passCount  = 0;

    score_hud dut (
        .Clk50      (clock),
        .Reset_n    (resetN),
        .frame_tick (frameTick),
        .Game_State (gameState),
        .Dead       (dead),
        .gift       (giftIn),
        .WriteX     (writeX),
        .WriteY     (writeY),
        .digit_on   (digitOn),
        .address    (romAddress),
        .score_out  (scoreOut),
        .hi_out     (hiOut)
    );

    // 100 MHz bench clock standing in for Clk50.
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle worth of control inputs and step to the next falling edge.
    task automatic applyStimulus(input logic ft, input logic [1:0] gs,
                                 input logic dd, input logic gf);
        frameTick = ft;
        gameState = gs;
        dead      = dd;
        giftIn    = gf;
        @(negedge clock);
    endtask

    task automatic runFrames(input int n, input logic [1:0] gs);
        repeat (n) applyStimulus(1'b1, gs, 1'b0, 1'b0);
    endtask

    task automatic giftPulses(input int n, input logic [1:0] gs);
        repeat (n) begin
            applyStimulus(1'b0, gs, 1'b0, 1'b1);
            applyStimulus(1'b0, gs, 1'b0, 1'b0);
        end
    endtask

    task automatic probePixel(input logic [9:0] x, input logic [9:0] y,
                              input logic [1:0] gs);
        writeX = x;
        writeY = y;
        applyStimulus(1'b0, gs, 1'b0, 1'b0);
    endtask

    // Hard stop in case something stalls the sequence below.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held for three edges with random inputs.
        resetN = 1'b0;
        for (int r = 0; r < 3; r++) begin
            frameTick = 1'($urandom_range(0, 1));
            gameState = 2'($urandom_range(0, 3));
            dead      = 1'($urandom_range(0, 1));
            giftIn    = 1'($urandom_range(0, 1));
            writeX    = 10'($urandom_range(370, 620));
            writeY    = 10'($urandom_range(15, 45));
            @(negedge clock);
        end
        checkOutput("reset digit_on", 32'(digitOn), 32'd0);
        checkOutput("reset address", 32'(romAddress), 32'd0);
        checkOutput("reset score", scoreOut, 32'd0);
        checkOutput("reset hi", hiOut, 32'd0);

        resetN = 1'b1;
        writeX = 10'd0;
        writeY = 10'd0;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

        // Counting on the divided frame tick, then freeze in game over.
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        runFrames(25, 2'b01);
        checkOutput("count 25 ticks", scoreOut, 32'd2);
        checkOutput("hi during run", hiOut, 32'd0);
        runFrames(5, 2'b01);
        checkOutput("count 30 ticks", scoreOut, 32'd3);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        runFrames(20, 2'b10);
        checkOutput("over frozen score", scoreOut, 32'd3);
        checkOutput("over hi", hiOut, 32'd3);

        // Restart, then a held gift coinciding with a step.
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        checkOutput("restart clears", scoreOut, 32'd0);
        runFrames(9, 2'b01);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 2'b01, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        checkOutput("gift+step once", scoreOut, 32'd101);
        giftPulses(1, 2'b01);
        checkOutput("gift pulse", scoreOut, 32'd201);

        // Reach 12345 and probe the rendered rows.
        giftPulses(121, 2'b01);
        runFrames(440, 2'b01);
        checkOutput("score 12345", scoreOut, 32'd12345);
        probePixel(10'd563, 10'd22, 2'b01);
        checkOutput("render on", 32'(digitOn), 32'd1);
        checkOutput("render addr", 32'(romAddress), 32'd169388);
        probePixel(10'd600, 10'd20, 2'b01);
        checkOutput("render lsd addr", 32'(romAddress), 32'd170105);
        probePixel(10'd563, 10'd40, 2'b01);
        checkOutput("render last row", 32'(romAddress), 32'd169712);
        probePixel(10'd563, 10'd41, 2'b01);
        checkOutput("below row off", 32'(digitOn), 32'd0);
        probePixel(10'd538, 10'd22, 2'b01);
        checkOutput("gap off", 32'(digitOn), 32'd0);
        checkOutput("gap addr", 32'(romAddress), 32'd0);
        probePixel(10'd465, 10'd30, 2'b01);
        checkOutput("hi row on", 32'(digitOn), 32'd2);
        checkOutput("hi row addr", 32'(romAddress), 32'd169534);
        probePixel(10'd381, 10'd20, 2'b01);
        checkOutput("hi leading zero", 32'(romAddress), 32'd168216);

        // Top of range and wrap.
        giftPulses(876, 2'b01);
        runFrames(540, 2'b01);
        checkOutput("score 99999", scoreOut, 32'd99999);
        probePixel(10'd600, 10'd20, 2'b01);
        checkOutput("digit nine addr", 32'(romAddress), 32'd171617);
        runFrames(10, 2'b01);
        checkOutput("wrap to 0", scoreOut, 32'd0);

        // Milestone 99 -> 100 and the blink pattern on the least digit.
        runFrames(990, 2'b01);
        checkOutput("score 99", scoreOut, 32'd99);
        runFrames(9, 2'b01);
        writeX = 10'd600;
        writeY = 10'd20;
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        checkOutput("score 100", scoreOut, 32'd100);
        for (int k = 1; k <= 201; k++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
            applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
            if (k == 1 || k == 25 || k == 51 || k == 200 || k == 201) begin
                checkOutput($sformatf("blink visible k=%0d", k), 32'(digitOn), 32'd1);
            end else if (k == 26 || k == 50 || k == 199) begin
                checkOutput($sformatf("blink hidden k=%0d", k), 32'(digitOn), 32'd0);
            end
            if (k == 25) begin
                checkOutput("blink lsd zeroed", 32'(romAddress), 32'd168215);
            end
        end
        runFrames(30, 2'b01);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        checkOutput("steady score", scoreOut, 32'd123);
        checkOutput("steady lsd addr", 32'(romAddress), 32'd169349);

        // Reset in the middle of a run discards everything.
        resetN = 1'b0;
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        checkOutput("midrun reset score", scoreOut, 32'd0);
        checkOutput("midrun reset hi", hiOut, 32'd0);
        checkOutput("midrun reset on", 32'(digitOn), 32'd0);
        resetN = 1'b1;

        // High score survives a weaker second run.
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        runFrames(500, 2'b01);
        checkOutput("run to 50", scoreOut, 32'd50);
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
        checkOutput("hi 50", hiOut, 32'd50);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        checkOutput("rerun clears", scoreOut, 32'd0);
        runFrames(400, 2'b01);
        checkOutput("run to 40", scoreOut, 32'd40);
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
        runFrames(20, 2'b10);
        checkOutput("hi kept 50", hiOut, 32'd50);
        checkOutput("over frozen 40", scoreOut, 32'd40);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("idle hi 50", hiOut, 32'd50);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
